seq_param_dec_pipe: RTL and testbench

Parametrised, pipelined binary-to-vector decoder with latency-insensitive valid/ready interfaces on both sides. Each accepted transaction carries an index and a mode. It is decoded to a one-hot or thermometer vector of width `nbits`, flagged if the index is out of range, and held in a 2-entry output queue. The block sits between an index-producing stage and a consumer that applies back-pressure; it supersedes the purely combinational parametrised decoder wherever registered, flow-controlled decode is needed.

---
 rtl/seq_param_dec_pipe.sv | 126 ++++++++++++
 tb/tb_seq_param_dec_pipe.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_param_dec_pipe.sv
// seq_param_dec_pipe
//
// Registered, flow-controlled binary-to-vector decoder. Each accepted
// transaction {in_, mode} is decoded at enqueue time into a one-hot
// (mode 0) or thermometer (mode 1) vector of width nbits. An index at or
// above nbits yields an all-zero vector with err set. Results wait in a
// 2-entry FIFO until the consumer takes them.
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   synchronous, active-high reset
//   in_val   in   input transaction valid
//   in_rdy   out  block can accept a transaction this cycle
//   in_      in   binary index, $clog2(nbits) bits
//   mode     in   0 = one-hot, 1 = thermometer
//   out_val  out  head entry valid
//   out_rdy  in   consumer takes the head entry this cycle
//   out      out  decoded vector of the head entry (0 when empty)
//   err      out  head entry had an out-of-range index (0 when empty)
//   err_cnt  out  saturating count of accepted out-of-range transactions

module seq_param_dec_pipe #(
    parameter int unsigned nbits = 8,
    localparam int unsigned IdxW = $clog2(nbits)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_val,
    output logic              in_rdy,
    input  logic [IdxW-1:0]   in_,
    input  logic              mode,
    output logic              out_val,
    input  logic              out_rdy,
    output logic [nbits-1:0]  out,
    output logic              err,
    output logic [7:0]        err_cnt
);

    // One extra bit so nbits itself is representable for the range check.
    localparam int unsigned CmpW = IdxW + 1;
    localparam logic [CmpW-1:0] NbitsW = CmpW'(nbits);

    // Queue entries are {err, vector}.
    logic [nbits:0]   head_q, head_d;
    logic [nbits:0]   tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    logic             idx_ok;
    logic [nbits-1:0] dec_vec;
    logic [nbits:0]   dec_entry;
    logic             enq;
    logic             deq;

    // Decode the incoming index.
    always_comb begin
        idx_ok  = {1'b0, in_} < NbitsW;
        dec_vec = '0;
        for (int unsigned i = 0; i < nbits; i++) begin
            if (mode) begin
                dec_vec[i] = CmpW'(i) <= {1'b0, in_};
            end else begin
                dec_vec[i] = CmpW'(i) == {1'b0, in_};
            end
        end
        // Out-of-range: no partial write, just the error flag.
        dec_entry = idx_ok ? {1'b0, dec_vec} : {1'b1, {nbits{1'b0}}};
    end

    // Handshakes. in_rdy depends only on registered state and reset.
    always_comb begin
        in_rdy  = (count_q < 2'd2) && !reset;
        out_val = count_q != 2'd0;
        enq     = in_val && in_rdy;
        deq     = out_val && out_rdy;
    end

    // Head is always slot 0; a dequeue shifts the tail forward.
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        err_cnt_d = err_cnt_q;

        if (enq && deq) begin
            // Only reachable at count 1: the new entry becomes head.
            head_d = dec_entry;
        end else if (deq) begin
            head_d  = tail_q;
            count_d = count_q - 2'd1;
        end else if (enq) begin
            if (count_q == 2'd0) begin
                head_d = dec_entry;
            end else begin
                tail_d = dec_entry;
            end
            count_d = count_q + 2'd1;
        end

        if (enq && !idx_ok && (err_cnt_q != 8'hff)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= 2'd0;
            err_cnt_q <= 8'd0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Stale head contents are masked while the queue is empty.
    always_comb begin
        out     = out_val ? head_q[nbits-1:0] : '0;
        err     = out_val ? head_q[nbits] : 1'b0;
        err_cnt = err_cnt_q;
    end

endmodule

// File: tb/tb_seq_param_dec_pipe.sv
// Bench for seq_param_dec_pipe. Two instances (nbits=8 and nbits=5, both with
// a 3-bit index) share one stimulus stream; each has its own scoreboard queue
// and error-count model.

module tb_seq_param_dec_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_val;
    logic [2:0] in_;
    logic       mode;
    logic       out_rdy;

    logic       in_rdy8, out_val8, err8;
    logic [7:0] out8, err_cnt8;
    logic       in_rdy5, out_val5, err5;
    logic [4:0] out5;
    logic [7:0] err_cnt5;

    int total = 0;
    int bad   = 0;

    logic [8:0] q8[$];
    logic [5:0] q5[$];
    int         ec8 = 0;
    int         ec5 = 0;
    bit         known = 1'b0;

    always #5 clk = ~clk;

    seq_param_dec_pipe #(.nbits(8)) u_dut8 (
        .clk     (clk),
        .reset   (reset),
        .in_val  (in_val),
        .in_rdy  (in_rdy8),
        .in_     (in_),
        .mode    (mode),
        .out_val (out_val8),
        .out_rdy (out_rdy),
        .out     (out8),
        .err     (err8),
        .err_cnt (err_cnt8)
    );

    seq_param_dec_pipe #(.nbits(5)) u_dut5 (
        .clk     (clk),
        .reset   (reset),
        .in_val  (in_val),
        .in_rdy  (in_rdy5),
        .in_     (in_),
        .mode    (mode),
        .out_val (out_val5),
        .out_rdy (out_rdy),
        .out     (out5),
        .err     (err5),
        .err_cnt (err_cnt5)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference decode: {err, vector} with err at bit n.
    function automatic logic [256:0] model(input int n, input int idx, input bit m);
        logic [256:0] v;
        if (idx >= n) v = 257'(1) << n;
        else if (m)   v = (257'(2) << idx) - 257'(1);
        else          v = 257'(1) << idx;
        return v;
    endfunction

    // Called just after a falling edge with inputs already driven: check,
    // update the scoreboards, advance to the next falling edge.
    task automatic cycle();
        bit         rdy8, rdy5, enq8, enq5, deq8, deq5;
        logic [256:0] v;
        logic [8:0] e8;
        logic [5:0] e5;
        #1;
        rdy8 = (q8.size() < 2) && !reset;
        rdy5 = (q5.size() < 2) && !reset;
        if (reset) begin
            chk("in_rdy8_rst", 32'(in_rdy8), 32'(0));
            chk("in_rdy5_rst", 32'(in_rdy5), 32'(0));
        end
        if (known) begin
            if (!reset) begin
                chk("in_rdy8", 32'(in_rdy8), 32'(rdy8));
                chk("in_rdy5", 32'(in_rdy5), 32'(rdy5));
            end
            chk("out_val8", 32'(out_val8), 32'(q8.size() != 0));
            chk("out_val5", 32'(out_val5), 32'(q5.size() != 0));
            if (q8.size() != 0) begin
                e8 = q8[0];
                chk("out8", 32'(out8), 32'(e8[7:0]));
                chk("err8", 32'(err8), 32'(e8[8]));
            end else begin
                chk("out8_empty", 32'(out8), 32'(0));
                chk("err8_empty", 32'(err8), 32'(0));
            end
            if (q5.size() != 0) begin
                e5 = q5[0];
                chk("out5", 32'(out5), 32'(e5[4:0]));
                chk("err5", 32'(err5), 32'(e5[5]));
            end else begin
                chk("out5_empty", 32'(out5), 32'(0));
                chk("err5_empty", 32'(err5), 32'(0));
            end
            chk("err_cnt8", 32'(err_cnt8), 32'(ec8));
            chk("err_cnt5", 32'(err_cnt5), 32'(ec5));
        end
        enq8 = in_val && rdy8;
        enq5 = in_val && rdy5;
        deq8 = (q8.size() != 0) && out_rdy;
        deq5 = (q5.size() != 0) && out_rdy;
        if (reset) begin
            q8.delete();
            q5.delete();
            ec8 = 0;
            ec5 = 0;
            known = 1'b1;
        end else begin
            if (deq8) void'(q8.pop_front());
            if (deq5) void'(q5.pop_front());
            if (enq8) begin
                v = model(8, int'(in_), mode);
                q8.push_back(v[8:0]);
                if (int'(in_) >= 8 && ec8 < 255) ec8++;
            end
            if (enq5) begin
                v = model(5, int'(in_), mode);
                q5.push_back(v[5:0]);
                if (int'(in_) >= 5 && ec5 < 255) ec5++;
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input int idx, input bit m);
        in_val = v;
        in_    = 3'(idx);
        mode   = m;
    endtask

    initial begin
        reset   = 1'b1;
        out_rdy = 1'b1;
        drive(0, 0, 0);

        // Reset for two cycles, then idle.
        cycle();
        cycle();
        reset = 1'b0;
        cycle();

        // One-hot / thermometer (nbits=5 sees index 5 as out of range).
        drive(1, 5, 0); cycle();
        drive(1, 5, 1); cycle();
        drive(1, 0, 1); cycle();
        drive(0, 0, 0); cycle(); cycle();

        // Out of range on the narrow instance, from a clean error count.
        reset = 1'b1; cycle(); reset = 1'b0;
        drive(1, 4, 1); cycle();
        drive(1, 5, 0); cycle();
        drive(1, 6, 1); cycle();
        drive(1, 7, 0); cycle();
        drive(0, 0, 0); cycle(); cycle();
        chk("err_cnt5_three", 32'(err_cnt5), 32'(3));

        // Back-pressure: two accepted, third held until space frees up.
        out_rdy = 1'b0;
        drive(1, 1, 0); cycle();
        drive(1, 2, 0); cycle();
        drive(1, 3, 0); cycle(); cycle();
        out_rdy = 1'b1; cycle(); cycle();
        drive(0, 0, 0); cycle(); cycle(); cycle();

        // Streaming: one result per cycle, queue stays at one entry.
        for (int i = 0; i < 8; i++) begin
            drive(1, i, i[0]);
            cycle();
        end
        drive(0, 0, 0); cycle(); cycle();

        // Reset while the queue is full.
        out_rdy = 1'b0;
        drive(1, 6, 1); cycle();
        drive(1, 2, 0); cycle();
        reset = 1'b1; cycle();
        reset = 1'b0; drive(0, 0, 0); out_rdy = 1'b1; cycle();
        cycle();

        // Random traffic with random back-pressure.
        for (int i = 0; i < 60; i++) begin
            drive(bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                  bit'($urandom_range(0, 1)));
            out_rdy = bit'($urandom_range(0, 1));
            cycle();
        end
        out_rdy = 1'b1;
        drive(0, 0, 0); cycle(); cycle(); cycle();

        // Saturation: 300 out-of-range enqueues on the narrow instance.
        for (int i = 0; i < 300; i++) begin
            drive(1, 7, bit'($urandom_range(0, 1)));
            cycle();
        end
        drive(0, 0, 0); cycle(); cycle();
        chk("err_cnt5_sat", 32'(err_cnt5), 32'(255));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
